// File: rtl/psum_writeback.sv
// psum_writeback: captures a row of signed partial sums from the PE grid,
// saturates each lane to the memory data width and streams the lanes out
// as a ready/valid write burst starting at base_addr + row_idx*row_stride.
// Optional build macro PSUM_RELU_EN: negative lanes are written as zero
// (and never count as saturated).
module psum_writeback #(
    parameter int NUM_LANES = 14,
    parameter int PSUM_W    = 32,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        store_req,
    input  logic [3:0]                  num_valid,
    input  logic [7:0]                  row_idx,
    input  logic [7:0]                  row_stride,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [PSUM_W*NUM_LANES-1:0] psum_out,
    output logic                        mem_wr_en,
    output logic [ADDR_W-1:0]           mem_wr_addr,
    output logic [DATA_W-1:0]           mem_wr_data,
    input  logic                        mem_wr_ready,
    output logic                        store_busy,
    output logic                        store_done,
    output logic                        sat_flag
);

    // Counter wide enough for both the 4-bit request count and NUM_LANES.
    localparam int CNT_W = ($clog2(NUM_LANES + 1) > 4) ? $clog2(NUM_LANES + 1) : 4;
    localparam logic [CNT_W-1:0] LANES_C = CNT_W'(NUM_LANES);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    lane_q, lane_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   row_base_q, row_base_d;
    logic                sat_q, sat_d;
    logic [PSUM_W-1:0]   buf_q [NUM_LANES];

    logic                capture;
    logic                accept;
    logic [15:0]         row_off;
    logic [CNT_W-1:0]    nv_clamped;
    logic [PSUM_W-1:0]   cur_val;
    logic [PSUM_W-1:0]   act_val;
    logic [DATA_W-1:0]   cur_sat;
    logic                cur_clamped;
    logic [PSUM_W-DATA_W:0] upper_bits;

    assign capture = (state_q == IDLE) && store_req;
    assign accept  = (state_q == WRITE) && mem_wr_ready;
    assign row_off = {8'd0, row_idx} * {8'd0, row_stride};

    // Requests for more lanes than exist are trimmed to the full row.
    always_comb begin
        nv_clamped = CNT_W'(num_valid);
        if (CNT_W'(num_valid) > LANES_C) begin
            nv_clamped = LANES_C;
        end
    end

    // Lane buffer: snapshot of psum_out so later grid activity cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                buf_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                buf_q[i] <= psum_out[i*PSUM_W +: PSUM_W];
            end
        end
    end

    // Select the current lane, optionally rectify, then saturate to DATA_W.
    always_comb begin
        cur_val = '0;
        if (lane_q < LANES_C) begin
            cur_val = buf_q[lane_q];
        end
        act_val = cur_val;
`ifdef PSUM_RELU_EN
        if (cur_val[PSUM_W-1]) begin
            act_val = '0;
        end
`else
`endif
        // Value fits when all bits above the DATA_W sign bit match it.
        upper_bits  = act_val[PSUM_W-1:DATA_W-1];
        cur_clamped = !((&upper_bits) || !(|upper_bits));
        cur_sat     = act_val[DATA_W-1:0];
        if (cur_clamped) begin
            cur_sat = act_val[PSUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                        : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lane_q     <= '0;
            count_q    <= '0;
            row_base_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            count_q    <= count_d;
            row_base_q <= row_base_d;
            sat_q      <= sat_d;
        end
    end

    // Next-state logic: accept a store, walk lanes on each accepted write, pulse done.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        count_d    = count_q;
        row_base_d = row_base_q;
        sat_d      = sat_q;
        case (state_q)
            IDLE: begin
                if (store_req) begin
                    count_d    = nv_clamped;
                    row_base_d = base_addr + ADDR_W'(row_off);
                    lane_d     = '0;
                    sat_d      = 1'b0;
                    state_d    = (nv_clamped == '0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (accept) begin
                    if (cur_clamped) begin
                        sat_d = 1'b1;
                    end
                    if (lane_q == count_q - 1'b1) begin
                        state_d = DONE;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs derive from registered state only, so they hold while stalled.
    always_comb begin
        mem_wr_en   = (state_q == WRITE);
        mem_wr_addr = '0;
        mem_wr_data = '0;
        if (state_q == WRITE) begin
            mem_wr_addr = row_base_q + ADDR_W'(lane_q);
            mem_wr_data = cur_sat;
        end
        store_busy = (state_q != IDLE);
        store_done = (state_q == DONE);
        sat_flag   = sat_q;
    end

endmodule
